// File: rtl/instr_mem_pkg.sv
// Definitions shared by the instruction memory and its byte-stream loader.
package instr_mem_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int MEM_DEPTH   = 256;

  // Loader FSM encoding.
  typedef logic [2:0] loader_state_t;
  localparam loader_state_t ST_IDLE    = 3'd0;
  localparam loader_state_t ST_LEN_HI  = 3'd1;
  localparam loader_state_t ST_LEN_LO  = 3'd2;
  localparam loader_state_t ST_DATA_HI = 3'd3;
  localparam loader_state_t ST_DATA_LO = 3'd4;
  localparam loader_state_t ST_DONE    = 3'd5;
  localparam loader_state_t ST_ERROR   = 3'd6;

endpackage

// File: rtl/instr_mem_loader.sv
// Packs a length-prefixed big-endian byte stream into 16-bit words and writes
// them to instruction memory from address 0, holding the CPU while loading.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int INSTR_WIDTH_P = INSTR_WIDTH,
  parameter int DEPTH        = MEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [INSTR_WIDTH_P-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_hold
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  loader_state_t    state_r;
  logic [15:0]      count_r;
  logic [CNT_W-1:0] idx_r;
  logic [7:0]       hi_r;

  logic             loading_s;
  logic [15:0]      len_s;
  logic             last_s;

  // Decode of the current state and the length/last-word comparisons.
  always_comb begin
    loading_s = (state_r == ST_LEN_HI) || (state_r == ST_LEN_LO) ||
                (state_r == ST_DATA_HI) || (state_r == ST_DATA_LO);
    len_s     = {count_r[15:8], byte_data};
    last_s    = ((32'(idx_r) + 32'd1) == 32'(count_r));
  end

  assign byte_ready = loading_s;
  assign busy       = loading_s;
  assign cpu_hold   = loading_s;
  assign done       = (state_r == ST_DONE);
  assign error      = (state_r == ST_ERROR);

  // Loader FSM, word counter, holding register and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= 16'd0;
      idx_r   <= '0;
      hi_r    <= 8'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r <= ST_LEN_HI;
            idx_r   <= '0;
          end
        end
        ST_LEN_HI: begin
          if (byte_valid) begin
            count_r[15:8] <= byte_data;
            state_r       <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (byte_valid) begin
            count_r[7:0] <= byte_data;
            // Oversized lengths are rejected here, before any write can occur.
            if (len_s == 16'd0) begin
              state_r <= ST_DONE;
            end else if (32'(len_s) > 32'(DEPTH)) begin
              state_r <= ST_ERROR;
            end else begin
              state_r <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (byte_valid) begin
            hi_r    <= byte_data;
            state_r <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (byte_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= ADDR_WIDTH'(idx_r);
            wr_data <= INSTR_WIDTH_P'({hi_r, byte_data});
            idx_r   <= idx_r + CNT_W'(1);
            state_r <= last_s ? ST_DONE : ST_DATA_HI;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a byte-count model of the stream
// protocol predicts every output cycle by cycle under random stalls.
module tb_instr_mem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  instr_mem_loader #(.ADDR_WIDTH(32), .INSTR_WIDTH_P(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: progress measured in bytes consumed from the stream.
  byte unsigned stream[$];
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  int          m_c      = 0;
  int          m_n      = 0;
  logic [15:0] mem [0:255];
  int          wr_count;
  int          last_addr;

  typedef struct {
    int n;
    int stall_pct;
    bit mid_start;
    int exp_writes;
    bit exp_done;
    bit exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic build(input int n);
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n <= DEPTH) begin
      for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
    end
  endtask

  // One clock: drive at the falling edge, predict, then compare at the next one.
  task automatic cycle(input bit st, input bit vld);
    bit          ew;
    logic [31:0] ea;
    logic [15:0] ed;
    ew = 1'b0; ea = 32'd0; ed = 16'd0;
    start      = st;
    byte_valid = vld;
    byte_data  = (m_c < stream.size()) ? stream[m_c] : 8'($urandom);
    if (m_active) begin
      if (vld) begin
        if (m_c >= 3 && (m_c % 2) == 1) begin
          ew = 1'b1;
          ea = 32'((m_c - 3) / 2);
          ed = {stream[m_c-1], stream[m_c]};
        end
        if (m_c == 1) m_n = {stream[0], stream[1]};
        m_c++;
        if (m_c == 2 && (m_n == 0 || m_n > DEPTH)) begin
          m_active = 1'b0;
          m_done   = (m_n == 0);
          m_err    = (m_n > DEPTH);
        end else if (m_c > 2 && m_c == 2 + 2 * m_n) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (st) begin
      m_active = 1'b1;
      m_c = 0; m_done = 1'b0; m_err = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("byte_ready", 32'(byte_ready), 32'(m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
    chk("wr_en", 32'(wr_en), 32'(ew));
    if (ew) begin
      chk("wr_addr", wr_addr, ea);
      chk("wr_data", 32'(wr_data), 32'(ed));
    end
    if (wr_en) begin
      mem[wr_addr[7:0]] = wr_data;
      wr_count++;
      last_addr = int'(wr_addr);
    end
  endtask

  task automatic run_load(input int stall_pct, input bit mid_start);
    int guard;
    guard = 0;
    wr_count = 0;
    last_addr = -1;
    cycle(1'b1, 1'b1);
    while (m_active && guard < 5000) begin
      cycle(mid_start && guard == 7, $urandom_range(99, 0) >= stall_pct);
      guard++;
    end
    chk("load_timeout", 32'(m_active), 32'd0);
    repeat (3) cycle(1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 3,     stall_pct: 50, mid_start: 1'b0, exp_writes: 3,   exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{n: 0,     stall_pct: 0,  mid_start: 1'b0, exp_writes: 0,   exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{n: 256,   stall_pct: 20, mid_start: 1'b0, exp_writes: 256, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{n: 257,   stall_pct: 0,  mid_start: 1'b0, exp_writes: 0,   exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{n: 5,     stall_pct: 30, mid_start: 1'b1, exp_writes: 5,   exp_done: 1'b1, exp_err: 1'b0};
    vecs[5] = '{n: 1,     stall_pct: 60, mid_start: 1'b0, exp_writes: 1,   exp_done: 1'b1, exp_err: 1'b0};
    vecs[6] = '{n: 65535, stall_pct: 10, mid_start: 1'b0, exp_writes: 0,   exp_done: 1'b0, exp_err: 1'b1};

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Valid held high while idle: nothing may be consumed before a start.
    repeat (3) cycle(1'b0, 1'b1);

    // Basic load with fixed program and no stalls.
    stream.delete();
    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'hF0};
    run_load(0, 1'b0);
    chk("basic_nwr", 32'(wr_count), 32'd3);
    chk("basic_mem0", 32'(mem[0]), 32'h1234);
    chk("basic_mem1", 32'(mem[1]), 32'hABCD);
    chk("basic_mem2", 32'(mem[2]), 32'h0FF0);

    for (int v = 0; v < 7; v++) begin
      build(vecs[v].n);
      run_load(vecs[v].stall_pct, vecs[v].mid_start);
      chk("vec_nwr", 32'(wr_count), 32'(vecs[v].exp_writes));
      chk("vec_done", 32'(done), 32'(vecs[v].exp_done));
      chk("vec_error", 32'(error), 32'(vecs[v].exp_err));
      if (vecs[v].exp_writes > 0) chk("vec_last_addr", 32'(last_addr), 32'(vecs[v].exp_writes - 1));
    end

    // Reset right after the first word of three is written.
    build(3);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
    chk("pre_reset_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_c = 0;
    build(2);
    run_load(25, 1'b0);
    chk("post_reset_nwr", 32'(wr_count), 32'd2);
    chk("post_reset_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
